// File: rtl/approx_serial_adder_pkg.sv
// Shared types for the bit-serial approximate adder: FSM state encoding and a
// behavioural reference of the lower-part-approximate sum.
package approx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int MAX_REF_W = 64;

    // Reference result: low approx_bits positions are XOR with the chain broken,
    // and the AND of the top approximate position seeds the exact section.
    function automatic logic [MAX_REF_W:0] approx_ref_add(
        input logic [MAX_REF_W-1:0] a,
        input logic [MAX_REF_W-1:0] b,
        input int                   width,
        input int                   approx_bits
    );
        logic [MAX_REF_W:0] res;
        logic               c;
        res = '0;
        c   = 1'b0;
        for (int i = 0; i < width; i++) begin
            if (i < approx_bits) begin
                res[i] = a[i] ^ b[i];
                if (i == approx_bits - 1) begin
                    c = a[i] & b[i];
                end else begin
                    c = 1'b0;
                end
            end else begin
                res[i] = a[i] ^ b[i] ^ c;
                c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            end
        end
        res[width] = c;
        return res;
    endfunction

endpackage

// File: rtl/approx_serial_adder_bit_cell.sv
// One-bit adder cell: half adder when approx is set (carry-in ignored),
// otherwise a full adder.
module adder_bit_cell (
    input  logic [1:0] in1,
    input  logic       cin,
    input  logic       approx,
    output logic       sum,
    output logic       cout
);

    // Select half-adder or full-adder arithmetic for the current bit pair.
    always_comb begin
        sum  = 1'b0;
        cout = 1'b0;
        if (approx) begin
            sum  = in1[0] ^ in1[1];
            cout = in1[0] & in1[1];
        end else begin
            sum  = in1[0] ^ in1[1] ^ cin;
            cout = (in1[0] & in1[1]) | (in1[0] & cin) | (in1[1] & cin);
        end
    end

endmodule

// File: rtl/approx_serial_adder.sv
// Bit-serial approximate adder: accepts an operand pair, adds one bit per cycle
// LSB first through adder_bit_cell, and returns a WIDTH+1-bit result.
module approx_serial_adder
    import approx_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_BITS = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in1,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     sum,
    output logic               busy
);

    localparam int                 CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]   LAST_IDX  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   APX_MASK  = ~({WIDTH{1'b1}} << APPROX_BITS);

    if (APPROX_BITS > WIDTH) begin : g_bad_approx
        $fatal(1, "approx_serial_adder: APPROX_BITS must not exceed WIDTH");
    end

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  apx_q;
    logic [WIDTH:0]    sum_q;
    logic              carry_d;
    logic              bit_sum_s;
    logic              bit_cout_s;

    // Operands and the approximation mask shift right, so bit 0 is always the current position.
    adder_bit_cell u_cell (
        .in1    ({b_q[0], a_q[0]}),
        .cin    (carry_q),
        .approx (apx_q[0]),
        .sum    (bit_sum_s),
        .cout   (bit_cout_s)
    );

    // Carry into the next position; only the top approximate bit forwards its AND.
    always_comb begin
        carry_d = 1'b0;
        if (apx_q[0]) begin
            if (!apx_q[1]) begin
                carry_d = bit_cout_s;
            end else begin
                carry_d = 1'b0;
            end
        end else begin
            carry_d = bit_cout_s;
        end
    end

    // Handshake FSM, bit counter, operand shifters and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            apx_q   <= '0;
            sum_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= in1[WIDTH-1:0];
                        b_q     <= in1[2*WIDTH-1:WIDTH];
                        apx_q   <= APX_MASK;
                        sum_q   <= '0;
                        cnt_q   <= '0;
                        carry_q <= 1'b0;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    apx_q   <= apx_q >> 1;
                    carry_q <= carry_d;
                    // Result bits enter at the top and reach their final position after WIDTH shifts.
                    if (cnt_q == LAST_IDX) begin
                        sum_q   <= {carry_d, bit_sum_s, sum_q[WIDTH-1:1]};
                        state_q <= ST_DONE;
                    end else begin
                        sum_q[WIDTH-1:0] <= {bit_sum_s, sum_q[WIDTH-1:1]};
                        cnt_q            <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN);
    assign sum       = sum_q;

endmodule

// File: tb/tb_approx_serial_adder.sv
// Directed bench: three adder instances (APPROX_BITS = 2, 0, 8) share stimulus.
module tb_approx_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in1;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, busy_a;
    logic [8:0]  sum_a;
    logic        in_ready_e, out_valid_e, busy_e;
    logic [8:0]  sum_e;
    logic        in_ready_f, out_valid_f, busy_f;
    logic [8:0]  sum_f;

    int checks;
    int errors;

    approx_serial_adder #(.WIDTH(8), .APPROX_BITS(2)) dut_apx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in1(in1), .out_valid(out_valid_a), .out_ready(out_ready), .sum(sum_a), .busy(busy_a)
    );

    approx_serial_adder #(.WIDTH(8), .APPROX_BITS(0)) dut_exact (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_e),
        .in1(in1), .out_valid(out_valid_e), .out_ready(out_ready), .sum(sum_e), .busy(busy_e)
    );

    approx_serial_adder #(.WIDTH(8), .APPROX_BITS(8)) dut_full (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_f),
        .in1(in1), .out_valid(out_valid_f), .out_ready(out_ready), .sum(sum_f), .busy(busy_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one operation with out_ready held high; reports latency and whether in_ready was seen during RUN.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output bit rdy_seen);
        in1       = {b, a};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        rdy_seen  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid_a && lat < 40) begin
            if (in_ready_a) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in1 = 16'h0000;
        #12;
        checks++; if (sum_a !== 9'h000 || out_valid_a !== 1'b0 || busy_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++; $display("FAIL reset_apx sum=%h ov=%b busy=%b ir=%b exp 000 0 0 1", sum_a, out_valid_a, busy_a, in_ready_a); end
        checks++; if (sum_e !== 9'h000 || out_valid_e !== 1'b0 || in_ready_e !== 1'b1) begin
            errors++; $display("FAIL reset_exact sum=%h ov=%b ir=%b exp 000 0 1", sum_e, out_valid_e, in_ready_e); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; bit rdy;
        run_op(8'h03, 8'h01, lat, rdy);
        checks++; if (lat !== 8) begin errors++; $display("FAIL latency got %0d exp 8", lat); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL in_ready_in_run got %b exp 0", rdy); end
        checks++; if (in_ready_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++; $display("FAIL done_flags ir=%b busy=%b exp 0 0", in_ready_a, busy_a); end
        checks++; if (sum_a !== 9'h002) begin errors++; $display("FAIL apx_03_01 got %h exp 002", sum_a); end
        checks++; if (sum_f !== 9'h002) begin errors++; $display("FAIL full_03_01 got %h exp 002", sum_f); end
        finish_op();
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || sum_a !== 9'h002) begin
            errors++; $display("FAIL after_hs ov=%b ir=%b sum=%h exp 0 1 002", out_valid_a, in_ready_a, sum_a); end

        run_op(8'hFF, 8'h01, lat, rdy);
        checks++; if (sum_a !== 9'h0FE) begin errors++; $display("FAIL apx_ff_01 got %h exp 0fe", sum_a); end
        checks++; if (sum_e !== 9'h100) begin errors++; $display("FAIL exact_ff_01 got %h exp 100", sum_e); end
        finish_op();

        run_op(8'hFF, 8'hFF, lat, rdy);
        checks++; if (sum_a !== 9'h1FC) begin errors++; $display("FAIL apx_ff_ff got %h exp 1fc", sum_a); end
        checks++; if (sum_e !== 9'h1FE) begin errors++; $display("FAIL exact_ff_ff got %h exp 1fe", sum_e); end
        checks++; if (sum_f !== 9'h100) begin errors++; $display("FAIL full_ff_ff got %h exp 100", sum_f); end
        finish_op();
    endtask

    task automatic test_exact_and_full();
        int lat; bit rdy;
        run_op(8'hA5, 8'h5A, lat, rdy);
        checks++; if (sum_e !== 9'h0FF) begin errors++; $display("FAIL exact_a5_5a got %h exp 0ff", sum_e); end
        checks++; if (sum_f !== 9'h0FF) begin errors++; $display("FAIL full_a5_5a got %h exp 0ff", sum_f); end
        finish_op();
        run_op(8'hFF, 8'h81, lat, rdy);
        checks++; if (sum_f !== 9'h17E) begin errors++; $display("FAIL full_ff_81 got %h exp 17e", sum_f); end
        checks++; if (sum_e !== 9'h180) begin errors++; $display("FAIL exact_ff_81 got %h exp 180", sum_e); end
        checks++; if (sum_a !== 9'h17E) begin errors++; $display("FAIL apx_ff_81 got %h exp 17e", sum_a); end
        finish_op();
    endtask

    task automatic test_backpressure();
        int n;
        bit stable_ok;
        out_ready = 1'b0;
        in1       = {8'h0F, 8'h55};
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid_a && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 8) begin errors++; $display("FAIL bp_latency got %0d exp 8", n); end
        in1       = {8'h20, 8'h10};
        in_valid  = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid_a !== 1'b1 || sum_a !== 9'h062 || in_ready_a !== 1'b0) stable_ok = 1'b0;
        end
        checks++; if (stable_ok !== 1'b1 || sum_a !== 9'h062) begin
            errors++; $display("FAIL bp_hold sum=%h ov=%b exp 062 1 throughout", sum_a, out_valid_a); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || busy_a !== 1'b0 || sum_a !== 9'h062) begin
            errors++; $display("FAIL bp_release ov=%b ir=%b busy=%b sum=%h exp 0 1 0 062", out_valid_a, in_ready_a, busy_a, sum_a); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL bp_second_accept busy=%b exp 1", busy_a); end
        n = 0;
        while (!out_valid_a && n < 40) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 8 || sum_a !== 9'h030) begin
            errors++; $display("FAIL bp_second_op lat=%0d sum=%h exp 8 030", n, sum_a); end
        finish_op();
    endtask

    task automatic test_reset_mid_run();
        int lat; bit rdy;
        in1       = {8'hFF, 8'hFF};
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
        checks++; if (busy_a !== 1'b1 || sum_a === 9'h000) begin
            errors++; $display("FAIL mid_run_state busy=%b sum=%h exp 1 nonzero", busy_a, sum_a); end
        rst_n = 1'b0;
        #1;
        checks++; if (sum_a !== 9'h000 || busy_a !== 1'b0 || out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
            errors++; $display("FAIL mid_run_reset sum=%h busy=%b ov=%b ir=%b exp 000 0 0 1", sum_a, busy_a, out_valid_a, in_ready_a); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h10, 8'h20, lat, rdy);
        checks++; if (lat !== 8 || sum_a !== 9'h030) begin
            errors++; $display("FAIL post_reset_op lat=%0d sum=%h exp 8 030", lat, sum_a); end
        finish_op();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_exact_and_full();
        test_backpressure();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
